// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the RISC-V core.
// Aligns and extends load data, flags faulting loads, and presents three
// registered writeback candidates plus a sanitised select to the WB mux.
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic [XLEN-1:0]       in_mem_rdata,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic                  in_mem_read,
  input  logic [2:0]            in_funct3,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [XLEN-1:0]       wb_mem_data,
  output logic [XLEN-1:0]       wb_pc_plus4,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  wb_valid,
  output logic                  wb_load_fault
);

  // What the stage registers do at the next rising edge.
  typedef enum logic [1:0] {
    ST_CAPTURE = 2'b00,
    ST_HOLD    = 2'b01,
    ST_FLUSH   = 2'b10
  } update_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_mem_data;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [1:0]            r_sel;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_valid;
  logic                  r_load_fault;

  logic [1:0]            w_addr_lo;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_aligned;
  logic                  w_fault;
  logic [XLEN-1:0]       w_mem_data;
  logic                  w_reg_write;
  logic [1:0]            w_sel;
  logic                  w_load_fault;
  update_e               w_action;

  assign w_addr_lo = in_alu_result[1:0];

  // Pick the addressed byte/half out of the raw word and extend it; also
  // decide whether this load is misaligned or uses an undefined funct3.
  always_comb begin
    w_byte    = 8'h00;
    w_half    = 16'h0000;
    w_aligned = '0;
    w_fault   = 1'b0;
    case (w_addr_lo)
      2'b00:   w_byte = in_mem_rdata[7:0];
      2'b01:   w_byte = in_mem_rdata[15:8];
      2'b10:   w_byte = in_mem_rdata[23:16];
      default: w_byte = in_mem_rdata[31:24];
    endcase
    w_half = w_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    case (in_funct3)
      F3_LB:  w_aligned = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: w_aligned = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        w_aligned = {{(XLEN-16){w_half[15]}}, w_half};
        w_fault   = w_addr_lo[0];
      end
      F3_LHU: begin
        w_aligned = {{(XLEN-16){1'b0}}, w_half};
        w_fault   = w_addr_lo[0];
      end
      F3_LW: begin
        w_aligned = in_mem_rdata;
        w_fault   = (w_addr_lo != 2'b00);
      end
      default: begin
        w_aligned = '0;
        w_fault   = 1'b1;
      end
    endcase
    if (!in_mem_read) begin
      w_fault = 1'b0;
    end
  end

  // Build the values a capture would load, qualifying control by valid.
  always_comb begin
    w_mem_data   = '0;
    w_reg_write  = 1'b0;
    w_sel        = SEL_ALU;
    w_load_fault = 1'b0;
    if (in_mem_read && !w_fault) begin
      w_mem_data = w_aligned;
    end
    w_reg_write  = in_valid && in_reg_write && (in_rd != '0) && !w_fault;
    w_load_fault = in_valid && w_fault;
    if (in_valid && (in_wb_sel != SEL_BAD)) begin
      w_sel = in_wb_sel;
    end
  end

  // Flush beats stall, stall beats capture.
  always_comb begin
    w_action = ST_CAPTURE;
    if (flush) begin
      w_action = ST_FLUSH;
    end else if (stall) begin
      w_action = ST_HOLD;
    end
  end

  // Stage registers: cleared by reset or flush, frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_pc_plus4   <= '0;
      r_sel        <= SEL_ALU;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_valid      <= 1'b0;
      r_load_fault <= 1'b0;
    end else begin
      case (w_action)
        ST_FLUSH: begin
          r_alu_result <= '0;
          r_mem_data   <= '0;
          r_pc_plus4   <= '0;
          r_sel        <= SEL_ALU;
          r_rd         <= '0;
          r_reg_write  <= 1'b0;
          r_valid      <= 1'b0;
          r_load_fault <= 1'b0;
        end
        ST_CAPTURE: begin
          r_alu_result <= in_alu_result;
          r_mem_data   <= w_mem_data;
          r_pc_plus4   <= in_pc_plus4;
          r_sel        <= w_sel;
          r_rd         <= in_rd;
          r_reg_write  <= w_reg_write;
          r_valid      <= in_valid;
          r_load_fault <= w_load_fault;
        end
        default: begin
          r_alu_result <= r_alu_result;
          r_mem_data   <= r_mem_data;
          r_pc_plus4   <= r_pc_plus4;
          r_sel        <= r_sel;
          r_rd         <= r_rd;
          r_reg_write  <= r_reg_write;
          r_valid      <= r_valid;
          r_load_fault <= r_load_fault;
        end
      endcase
    end
  end

  assign wb_alu_result = r_alu_result;
  assign wb_mem_data   = r_mem_data;
  assign wb_pc_plus4   = r_pc_plus4;
  assign wb_sel        = r_sel;
  assign wb_rd         = r_rd;
  assign wb_reg_write  = r_reg_write;
  assign wb_valid      = r_valid;
  assign wb_load_fault = r_load_fault;

  // The mux select must never present the illegal encoding.
  always_comb begin
    assert (!rst_n || r_sel != SEL_BAD);
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases followed by randomized traffic
// checked against a reference model of the stage written from its rules.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        inValid;
  logic [31:0] inAluResult;
  logic [31:0] inPcPlus4;
  logic [31:0] inMemRdata;
  logic [4:0]  inRd;
  logic        inRegWrite;
  logic [1:0]  inWbSel;
  logic        inMemRead;
  logic [2:0]  inFunct3;

  logic [31:0] wbAluResult;
  logic [31:0] wbMemData;
  logic [31:0] wbPcPlus4;
  logic [1:0]  wbSel;
  logic [4:0]  wbRd;
  logic        wbRegWrite;
  logic        wbValid;
  logic        wbLoadFault;

  int testsRun;
  int testsFailed;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t expState;

  mem_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (inValid),
    .in_alu_result(inAluResult),
    .in_pc_plus4  (inPcPlus4),
    .in_mem_rdata (inMemRdata),
    .in_rd        (inRd),
    .in_reg_write (inRegWrite),
    .in_wb_sel    (inWbSel),
    .in_mem_read  (inMemRead),
    .in_funct3    (inFunct3),
    .wb_alu_result(wbAluResult),
    .wb_mem_data  (wbMemData),
    .wb_pc_plus4  (wbPcPlus4),
    .wb_sel       (wbSel),
    .wb_rd        (wbRd),
    .wb_reg_write (wbRegWrite),
    .wb_valid     (wbValid),
    .wb_load_fault(wbLoadFault)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the stage should hold after capturing the current inputs.
  function automatic exp_t modelCapture();
    exp_t        e;
    int unsigned a;
    logic [31:0] byteVal;
    logic [31:0] halfVal;
    logic [31:0] loaded;
    bit          fault;
    e       = '0;
    a       = int'(inAluResult % 4);
    byteVal = (inMemRdata >> (8 * a)) & 32'hFF;
    halfVal = (inMemRdata >> (16 * (a / 2))) & 32'hFFFF;
    loaded  = 32'h0;
    fault   = 1'b0;
    case (inFunct3)
      3'd0: loaded = (byteVal >= 128) ? byteVal + 32'hFFFF_FF00 : byteVal;
      3'd4: loaded = byteVal;
      3'd1: begin
        loaded = (halfVal >= 32768) ? halfVal + 32'hFFFF_0000 : halfVal;
        fault  = (a % 2) != 0;
      end
      3'd5: begin
        loaded = halfVal;
        fault  = (a % 2) != 0;
      end
      3'd2: begin
        loaded = inMemRdata;
        fault  = a != 0;
      end
      default: fault = 1'b1;
    endcase
    if (!inMemRead) fault = 1'b0;
    e.alu   = inAluResult;
    e.pc    = inPcPlus4;
    e.mem   = (inMemRead && !fault) ? loaded : 32'h0;
    e.rd    = inRd;
    e.valid = inValid;
    e.fault = inValid && fault;
    e.rw    = inValid && inRegWrite && (inRd != 0) && !fault;
    e.sel   = (inValid && inWbSel != 2'd3) ? inWbSel : 2'd0;
    return e;
  endfunction

  // Compare every DUT output against the model's expected state.
  task automatic checkOutput(input string tag);
    testsRun++;
    assert (wbAluResult === expState.alu) else begin
      testsFailed++;
      $error("[TB] FAIL %s alu: got %h want %h", tag, wbAluResult, expState.alu);
    end
    testsRun++;
    assert (wbMemData === expState.mem) else begin
      testsFailed++;
      $error("[TB] FAIL %s mem: got %h want %h", tag, wbMemData, expState.mem);
    end
    testsRun++;
    assert (wbPcPlus4 === expState.pc) else begin
      testsFailed++;
      $error("[TB] FAIL %s pc4: got %h want %h", tag, wbPcPlus4, expState.pc);
    end
    testsRun++;
    assert (wbSel === expState.sel) else begin
      testsFailed++;
      $error("[TB] FAIL %s sel: got %b want %b", tag, wbSel, expState.sel);
    end
    testsRun++;
    assert (wbRd === expState.rd) else begin
      testsFailed++;
      $error("[TB] FAIL %s rd: got %0d want %0d", tag, wbRd, expState.rd);
    end
    testsRun++;
    assert (wbRegWrite === expState.rw) else begin
      testsFailed++;
      $error("[TB] FAIL %s reg_write: got %b want %b", tag, wbRegWrite, expState.rw);
    end
    testsRun++;
    assert (wbValid === expState.valid) else begin
      testsFailed++;
      $error("[TB] FAIL %s valid: got %b want %b", tag, wbValid, expState.valid);
    end
    testsRun++;
    assert (wbLoadFault === expState.fault) else begin
      testsFailed++;
      $error("[TB] FAIL %s fault: got %b want %b", tag, wbLoadFault, expState.fault);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [31:0] rdata,
                               input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                               input logic mr, input logic [2:0] f3,
                               input logic st, input logic fl);
    exp_t nextState;
    inValid = v; inAluResult = alu; inPcPlus4 = pc; inMemRdata = rdata;
    inRd = rd; inRegWrite = rw; inWbSel = sel; inMemRead = mr; inFunct3 = f3;
    stall = st; flush = fl;
    if (fl) nextState = '0;
    else if (st) nextState = expState;
    else nextState = modelCapture();
    @(posedge clk);
    expState = nextState;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    expState = '0;
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0; inValid = 1'b0; inAluResult = '0; inPcPlus4 = '0;
    inMemRdata = '0; inRd = '0; inRegWrite = 1'b0; inWbSel = '0; inMemRead = 1'b0;
    inFunct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_release");

    // Fill the stage, then drop reset mid-cycle and expect an immediate clear.
    applyStimulus("prefill", 1, 32'hDEAD_BEE0, 32'h44, 32'h1234_5678, 5'd7, 1, 2'd1, 1, 3'd2, 0, 0);
    #2;
    rst_n = 1'b0;
    expState = '0;
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("lb_sext", 1, 32'h1003, 32'h10, 32'h80F1_2380, 5'd5, 1, 2'd1, 1, 3'd0, 0, 0);
    testsRun++;
    assert (wbMemData === 32'hFFFF_FF80) else begin
      testsFailed++;
      $error("[TB] FAIL lb_const: got %h want %h", wbMemData, 32'hFFFF_FF80);
    end
    applyStimulus("lbu_zext", 1, 32'h1003, 32'h14, 32'h80F1_2380, 5'd5, 1, 2'd1, 1, 3'd4, 0, 0);
    testsRun++;
    assert (wbMemData === 32'h0000_0080) else begin
      testsFailed++;
      $error("[TB] FAIL lbu_const: got %h want %h", wbMemData, 32'h0000_0080);
    end
    applyStimulus("lh_high", 1, 32'h2002, 32'h18, 32'h8001_7FFF, 5'd6, 1, 2'd1, 1, 3'd1, 0, 0);
    testsRun++;
    assert (wbMemData === 32'hFFFF_8001) else begin
      testsFailed++;
      $error("[TB] FAIL lh_const: got %h want %h", wbMemData, 32'hFFFF_8001);
    end
    applyStimulus("lh_misalign", 1, 32'h2001, 32'h1C, 32'h8001_7FFF, 5'd6, 1, 2'd1, 1, 3'd1, 0, 0);
    testsRun++;
    assert (wbLoadFault === 1'b1 && wbRegWrite === 1'b0) else begin
      testsFailed++;
      $error("[TB] FAIL lh_fault_const: got fault=%b rw=%b want 1/0", wbLoadFault, wbRegWrite);
    end
    applyStimulus("lw_illegal_f3", 1, 32'h3000, 32'h20, 32'hCAFE_F00D, 5'd9, 1, 2'd1, 1, 3'd6, 0, 0);

    // Capture, hold through three stalled cycles of changing inputs, then flush.
    applyStimulus("cap_42", 1, 32'h42, 32'h24, 32'h0, 5'd3, 1, 2'd0, 0, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall_hold", 1, 32'h99 + i, 32'h30, 32'h5555_AAAA, 5'd12, 1, 2'd2, 1, 3'd2, 1, 0);
    end
    testsRun++;
    assert (wbAluResult === 32'h42 && wbRd === 5'd3) else begin
      testsFailed++;
      $error("[TB] FAIL stall_const: got %h/%0d want 42/3", wbAluResult, wbRd);
    end
    applyStimulus("flush_stall", 1, 32'h77, 32'h34, 32'h0, 5'd4, 1, 2'd2, 0, 3'd0, 1, 1);

    applyStimulus("rd_zero", 1, 32'h55, 32'h38, 32'h0, 5'd0, 1, 2'd0, 0, 3'd0, 0, 0);
    applyStimulus("sel_illegal", 1, 32'h56, 32'h3C, 32'h0, 5'd8, 1, 2'd3, 0, 3'd0, 0, 0);
    applyStimulus("jal", 1, 32'h200, 32'h108, 32'h0, 5'd1, 1, 2'd2, 0, 3'd0, 0, 0);
    testsRun++;
    assert (wbPcPlus4 === 32'h108 && wbSel === 2'b10) else begin
      testsFailed++;
      $error("[TB] FAIL jal_const: got %h/%b want 108/10", wbPcPlus4, wbSel);
    end
    applyStimulus("invalid", 0, 32'h57, 32'h40, 32'h0, 5'd8, 1, 2'd1, 0, 3'd0, 0, 0);

    // Four back-to-back valid instructions, each visible one cycle later.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("b2b", 1, 32'h100 + i, 32'h50 + 4 * i, 32'hA5A5_0000 + i, 5'(10 + i),
                    1, 2'd1, 1, 3'd2, 0, 0);
    end

    // Randomized traffic including stalls, flushes and random load shapes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", ($urandom_range(3) != 0), $urandom, $urandom, $urandom,
                    5'($urandom_range(31)), 1'($urandom_range(1)), 2'($urandom_range(3)),
                    1'($urandom_range(1)), 3'($urandom_range(7)),
                    ($urandom_range(4) == 0), ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
